// File: rtl/ia_packet_ctrl.sv
`default_nettype none
// ============================================================================
// ia_packet_ctrl - frames UART bytes into checksummed scene packets, commits at vsync
// Revision: 1.0
// ============================================================================
module ia_packet_ctrl #(
    parameter int unsigned  PAYLOAD = 54,
    parameter logic [7:0]   SYNC    = 8'hA5,
    parameter logic [15:0]  TIMEOUT = 16'hFFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       vsync,
    output logic [5:0] idx,
    output logic       update_reg,
    output logic       pc_ready,
    output logic       busy,
    output logic [3:0] err_cnt
);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        PEND  = 2'd3
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(PAYLOAD - 1);

    state_t      state, state_nx;
    logic [5:0]  cnt, cnt_nx;
    logic [7:0]  acc, acc_nx;
    logic [15:0] idle, idle_nx;
    logic [5:0]  idx_nx;
    logic        update_nx;
    logic        ready_nx;
    logic        err_inc;
    logic [3:0]  err_nx;
    logic        vsync_q;
    logic        vsync_fall;
    logic        timed_out;

    assign vsync_fall = vsync_q & ~vsync;
    // A byte arriving on the terminal-count cycle takes priority over the timeout.
    assign timed_out  = ~rx_done && (idle == TIMEOUT);

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        acc_nx    = acc;
        idle_nx   = idle;
        idx_nx    = idx;
        update_nx = 1'b0;
        ready_nx  = 1'b0;
        err_inc   = 1'b0;

        case (state)
            HUNT: begin
                if (rx_done && (rx_data == SYNC)) begin
                    cnt_nx   = 6'd0;
                    acc_nx   = 8'd0;
                    idle_nx  = 16'd0;
                    state_nx = LOAD;
                end
            end
            LOAD, CHECK: begin
                if (rx_done) begin
                    idle_nx = 16'd0;
                    if (state == LOAD) begin
                        idx_nx    = cnt;
                        update_nx = 1'b1;
                        acc_nx    = acc ^ rx_data;
                        cnt_nx    = cnt + 6'd1;
                        if (cnt == LAST_IDX) begin
                            state_nx = CHECK;
                        end
                    end else if (rx_data == acc) begin
                        state_nx = PEND;
                    end else begin
                        err_inc  = 1'b1;
                        state_nx = HUNT;
                    end
                end else if (timed_out) begin
                    err_inc  = 1'b1;
                    state_nx = HUNT;
                end else if (idle != 16'hFFFF) begin
                    idle_nx = idle + 16'd1;
                end
            end
            PEND: begin
                if (vsync_fall) begin
                    ready_nx = 1'b1;
                    state_nx = HUNT;
                end
            end
            default: state_nx = HUNT;
        endcase

        err_nx = (err_inc && (err_cnt != 4'hF)) ? err_cnt + 4'd1 : err_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HUNT;
            cnt        <= 6'd0;
            acc        <= 8'd0;
            idle       <= 16'd0;
            vsync_q    <= 1'b1;
            idx        <= 6'd0;
            update_reg <= 1'b0;
            pc_ready   <= 1'b0;
            busy       <= 1'b0;
            err_cnt    <= 4'd0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            acc        <= acc_nx;
            idle       <= idle_nx;
            vsync_q    <= vsync;
            idx        <= idx_nx;
            update_reg <= update_nx;
            pc_ready   <= ready_nx;
            busy       <= (state_nx != HUNT);
            err_cnt    <= err_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ia_packet_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ia_packet_ctrl - directed stimulus checked against a per-cycle packet model
// Revision: 1.0
// ============================================================================
module tb_ia_packet_ctrl;

    localparam int          PAYLOAD = 54;
    localparam logic [7:0]  SYNC    = 8'hA5;
    localparam int          TO      = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       vsync;
    logic [5:0] idx;
    logic       update_reg;
    logic       pc_ready;
    logic       busy;
    logic [3:0] err_cnt;

    ia_packet_ctrl #(
        .PAYLOAD (PAYLOAD),
        .SYNC    (SYNC),
        .TIMEOUT (16'(TO))
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .vsync      (vsync),
        .idx        (idx),
        .update_reg (update_reg),
        .pc_ready   (pc_ready),
        .busy       (busy),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    int pcs    = 0;
    bit chk_en = 1'b0;
    logic [7:0] bank [0:63];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet model: mode 0 hunting, 1 collecting payload, 2 awaiting checksum, 3 awaiting frame start
    int         m_mode = 0;
    int         m_n    = 0;
    int         m_gap  = 0;
    logic [7:0] m_sum  = 8'd0;
    bit         m_vprev = 1'b1;
    logic [5:0] e_idx  = 6'd0;
    logic       e_upd  = 1'b0;
    logic       e_rdy  = 1'b0;
    logic       e_busy = 1'b0;
    int         e_err  = 0;

    always @(posedge clk) begin
        e_upd = 1'b0;
        e_rdy = 1'b0;
        if (reset) begin
            m_mode = 0; m_n = 0; m_gap = 0; m_sum = 8'd0; m_vprev = 1'b1;
            e_idx = 6'd0; e_busy = 1'b0; e_err = 0;
        end else begin
            if (m_mode == 0) begin
                if (rx_done && rx_data == SYNC) begin
                    m_mode = 1; m_n = 0; m_sum = 8'd0; m_gap = 0;
                end
            end else if (m_mode == 1 || m_mode == 2) begin
                if (rx_done) begin
                    m_gap = 0;
                    if (m_mode == 1) begin
                        e_upd = 1'b1;
                        e_idx = 6'(m_n);
                        m_sum = m_sum ^ rx_data;
                        m_n++;
                        if (m_n == PAYLOAD) m_mode = 2;
                    end else if (rx_data == m_sum) begin
                        m_mode = 3;
                    end else begin
                        e_err  = (e_err < 15) ? e_err + 1 : 15;
                        m_mode = 0;
                    end
                end else begin
                    m_gap++;
                    if (m_gap > TO) begin
                        e_err  = (e_err < 15) ? e_err + 1 : 15;
                        m_mode = 0;
                    end
                end
            end else if (m_vprev && !vsync) begin
                e_rdy  = 1'b1;
                m_mode = 0;
            end
            e_busy  = (m_mode != 0);
            m_vprev = vsync;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("idx", 32'(idx), 32'(e_idx));
            chk("update_reg", 32'(update_reg), 32'(e_upd));
            chk("pc_ready", 32'(pc_ready), 32'(e_rdy));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("err_cnt", 32'(err_cnt), 32'(e_err));
            if (update_reg === 1'b1) begin
                bank[idx] = rx_data;
                writes++;
            end
            if (pc_ready === 1'b1) pcs++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    // Checksum sent is the true XOR folded with bad; bad==0 gives a valid packet.
    task automatic send_packet(input logic [7:0] first, input logic [7:0] step,
                               input logic [7:0] bad, input int gap_at, input int gap);
        logic [7:0] b;
        logic [7:0] s;
        s = 8'd0;
        send_byte(SYNC, 1);
        for (int k = 0; k < PAYLOAD; k++) begin
            b = first + 8'(k) * step;
            s = s ^ b;
            send_byte(b, (k == gap_at) ? gap : 1);
        end
        send_byte(s ^ bad, 1);
    endtask

    task automatic vsync_pulse();
        @(negedge clk);
        vsync = 1'b0;
        repeat (4) @(negedge clk);
        vsync = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w0, p0, bad_bytes;
        logic [7:0] s;
        reset = 1'b1; rx_done = 1'b0; rx_data = 8'h00; vsync = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_err", 32'(err_cnt), 32'd0);

        s = 8'd0;
        for (int k = 0; k < PAYLOAD; k++) s = s ^ 8'(k);
        chk("ref_checksum", 32'(s), 32'h01);

        // Valid ramp packet commits on the vsync falling edge
        send_packet(8'h00, 8'h01, 8'h00, -1, 1);
        #1;
        chk("t1_busy_pend", 32'(busy), 32'd1);
        chk("t1_writes", 32'(writes), 32'd54);
        chk("t1_no_early_pc", 32'(pcs), 32'd0);
        vsync_pulse();
        #1;
        chk("t1_pc", 32'(pcs), 32'd1);
        chk("t1_err", 32'(err_cnt), 32'd0);
        bad_bytes = 0;
        for (int k = 0; k < PAYLOAD; k++) if (bank[k] !== 8'(k)) bad_bytes++;
        chk("t1_bank", 32'(bad_bytes), 32'd0);

        // Same ramp with checksum 0x07 is rejected
        send_packet(8'h00, 8'h01, 8'h06, -1, 1);
        vsync_pulse();
        vsync_pulse();
        #1;
        chk("t2_writes", 32'(writes), 32'd108);
        chk("t2_pc", 32'(pcs), 32'd1);
        chk("t2_err", 32'(err_cnt), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);

        // Junk ahead of SYNC is dropped; first payload byte lands at idx 0
        send_byte(8'h12, 1);
        send_byte(8'h34, 1);
        #1;
        chk("t3_no_junk_write", 32'(writes), 32'd108);
        send_packet(8'h77, 8'h03, 8'h00, -1, 1);
        #1;
        chk("t3_bank0", 32'(bank[0]), 32'h77);
        vsync_pulse();
        #1;
        chk("t3_pc", 32'(pcs), 32'd2);

        // Idle timeout mid-packet, then a packet with a gap exactly at the limit
        send_byte(SYNC, 1);
        for (int k = 0; k < 10; k++) send_byte(8'(8'h50 + k), 1);
        repeat (TO + 5) @(negedge clk);
        #1;
        chk("t4_err", 32'(err_cnt), 32'd2);
        chk("t4_busy", 32'(busy), 32'd0);
        send_packet(8'h10, 8'h01, 8'h00, 30, TO);
        vsync_pulse();
        #1;
        chk("t4_boundary_err", 32'(err_cnt), 32'd2);
        chk("t4_pc", 32'(pcs), 32'd3);
        chk("t4_idx_last", 32'(idx), 32'd53);

        // Extra bytes while waiting for vsync, including a SYNC, are ignored
        send_packet(8'h20, 8'h05, 8'h00, -1, 1);
        w0 = writes;
        send_byte(8'h01, 1);
        send_byte(SYNC, 1);
        send_byte(8'h02, 2);
        send_byte(8'h03, 1);
        send_byte(8'h04, 3);
        #1;
        chk("t5_extra_writes", 32'(writes), 32'(w0));
        chk("t5_busy", 32'(busy), 32'd1);
        vsync_pulse();
        #1;
        chk("t5_pc", 32'(pcs), 32'd4);

        // Reset in the middle of LOAD, tail bytes must not write
        send_byte(SYNC, 1);
        for (int k = 0; k <= 20; k++) send_byte(8'(8'h80 + k), 1);
        #1;
        chk("t6_idx20", 32'(idx), 32'd20);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6_idx", 32'(idx), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_err", 32'(err_cnt), 32'd0);
        w0 = writes;
        p0 = pcs;
        for (int k = 0; k < 33; k++) send_byte(8'(8'h40 + k), 1);
        send_byte(8'h5A, 1);
        vsync_pulse();
        #1;
        chk("t6_tail_writes", 32'(writes), 32'(w0));
        chk("t6_tail_pc", 32'(pcs), 32'(p0));

        // Error counter saturates at 15
        for (int n = 0; n < 16; n++) send_packet(8'(n), 8'h01, 8'hFF, -1, 1);
        #1;
        chk("t7_err_sat", 32'(err_cnt), 32'd15);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
